// File: rtl/iob_sram_resp.sv
// IOb native bus responder backed by an internal word-addressed RAM.
// Configurable wait states before acceptance and read latency after it.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   avalid/address/wdata/wstrb  request (wstrb != 0 -> write, 0 -> read)
//   ready                 request is accepted at the next rising edge if avalid
//   rvalid/rdata          one-cycle read-data pulse; rdata holds between pulses
module iob_sram_resp #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned WAIT   = 0,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   avalid,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [(DATA_W/8)-1:0]  wstrb,
  output logic                   ready,
  output logic                   rvalid,
  output logic [DATA_W-1:0]      rdata
);

  localparam int unsigned WSTRB_W    = DATA_W / 8;
  localparam int unsigned DEPTH      = 1 << MEM_AW;
  localparam logic        READY_IDLE = 1'(WAIT == 0);

  typedef enum logic [1:0] {IDLE, WAITING, ACCEPT, RD_PIPE} state_t;

  state_t              state, state_n;
  logic [2:0]          wait_cnt, wait_cnt_n;
  logic [1:0]          lat_cnt, lat_cnt_n;
  logic [MEM_AW-1:0]   idx_q;
  logic                ready_n;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [MEM_AW-1:0]   addr_idx_c;
  logic [MEM_AW-1:0]   rd_idx_c;
  logic                accept_c, wr_c, rd_c, rd_fire_c;
  logic                unused_addr;

  // Byte offset and alias bits do not take part in word selection.
  assign unused_addr = ^{address[ADDR_W-1:MEM_AW+2], address[1:0]};

  // Request decode.
  always_comb begin
    addr_idx_c = address[MEM_AW+1:2];
    accept_c   = avalid & ready;
    wr_c       = accept_c & (|wstrb) & resetn;
    rd_c       = accept_c & ~(|wstrb);
    // Single-cycle latency returns data on the accept edge itself.
    rd_fire_c  = (rd_c && (RD_LAT == 1)) || ((state == RD_PIPE) && (lat_cnt == 2'd0));
    rd_idx_c   = (state == RD_PIPE) ? idx_q : addr_idx_c;
  end

  // Next-state logic; the rvalid cycle is spent in IDLE so a new request can be taken.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    lat_cnt_n  = lat_cnt;
    ready_n    = 1'b0;
    case (state)
      IDLE: begin
        if (WAIT == 0) begin
          if (rd_c && (RD_LAT > 1)) begin
            state_n   = RD_PIPE;
            lat_cnt_n = 2'(RD_LAT - 2);
          end
        end else if (avalid) begin
          // The cycle avalid is first seen counts as the first wait cycle.
          if (WAIT == 1) begin
            state_n = ACCEPT;
          end else begin
            state_n    = WAITING;
            wait_cnt_n = 3'(WAIT - 1);
          end
        end
      end
      WAITING: begin
        if (!avalid) begin
          state_n    = IDLE;
          wait_cnt_n = 3'd0;
        end else if (wait_cnt <= 3'd1) begin
          state_n    = ACCEPT;
          wait_cnt_n = 3'd0;
        end else begin
          wait_cnt_n = wait_cnt - 3'd1;
        end
      end
      ACCEPT: begin
        if (rd_c && (RD_LAT > 1)) begin
          state_n   = RD_PIPE;
          lat_cnt_n = 2'(RD_LAT - 2);
        end else begin
          state_n = IDLE;
        end
      end
      RD_PIPE: begin
        if (lat_cnt == 2'd0) begin
          state_n = IDLE;
        end else begin
          lat_cnt_n = lat_cnt - 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == ACCEPT) || ((state_n == IDLE) && READY_IDLE);
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      lat_cnt  <= 2'd0;
      idx_q    <= '0;
      ready    <= READY_IDLE;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      lat_cnt  <= lat_cnt_n;
      ready    <= ready_n;
      rvalid   <= rd_fire_c;
      if (rd_c) begin
        idx_q <= addr_idx_c;
      end
      if (rd_fire_c) begin
        rdata <= mem[rd_idx_c];
      end
    end
  end

  // Byte-masked write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      for (int i = 0; i < WSTRB_W; i++) begin
        if (wstrb[i]) begin
          mem[addr_idx_c][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_sram_resp.sv
// Bench for iob_sram_resp: four instances with different WAIT/RD_LAT settings,
// a reference memory model and a scoreboard of expected read responses.
module tb_iob_sram_resp;

  localparam int NI = 4;

  logic        clk;
  logic        resetn_s [NI];
  logic        avalid_s [NI];
  logic [31:0] address_s[NI];
  logic [31:0] wdata_s  [NI];
  logic [3:0]  wstrb_s  [NI];
  logic        ready_s  [NI];
  logic        rvalid_s [NI];
  logic [31:0] rdata_s  [NI];

  typedef struct {
    int          g;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  int          cyc;
  int          n_checks;
  int          n_fail;

  iob_sram_resp #(.WAIT(0), .RD_LAT(1)) u_w0l1 (
    .clk(clk), .resetn(resetn_s[0]), .avalid(avalid_s[0]), .address(address_s[0]),
    .wdata(wdata_s[0]), .wstrb(wstrb_s[0]), .ready(ready_s[0]), .rvalid(rvalid_s[0]),
    .rdata(rdata_s[0]));
  iob_sram_resp #(.WAIT(3), .RD_LAT(1)) u_w3l1 (
    .clk(clk), .resetn(resetn_s[1]), .avalid(avalid_s[1]), .address(address_s[1]),
    .wdata(wdata_s[1]), .wstrb(wstrb_s[1]), .ready(ready_s[1]), .rvalid(rvalid_s[1]),
    .rdata(rdata_s[1]));
  iob_sram_resp #(.WAIT(0), .RD_LAT(3)) u_w0l3 (
    .clk(clk), .resetn(resetn_s[2]), .avalid(avalid_s[2]), .address(address_s[2]),
    .wdata(wdata_s[2]), .wstrb(wstrb_s[2]), .ready(ready_s[2]), .rvalid(rvalid_s[2]),
    .rdata(rdata_s[2]));
  iob_sram_resp #(.WAIT(0), .RD_LAT(2)) u_w0l2 (
    .clk(clk), .resetn(resetn_s[3]), .avalid(avalid_s[3]), .address(address_s[3]),
    .wdata(wdata_s[3]), .wstrb(wstrb_s[3]), .ready(ready_s[3]), .rvalid(rvalid_s[3]),
    .rdata(rdata_s[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rd_lat(input int g);
    case (g)
      2:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int wait_of(input int g);
    return (g == 1) ? 3 : 0;
  endfunction

  function automatic int mkey(input int g, input logic [31:0] addr);
    return g * 1024 + int'(addr[11:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one request starting just after a rising edge; returns the number of
  // sampled cycles with ready low before acceptance.
  task automatic req(input int g, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output int waits);
    logic [31:0] w;
    int          key;
    avalid_s[g]  = 1'b1;
    address_s[g] = addr;
    wdata_s[g]   = data;
    wstrb_s[g]   = strb;
    waits        = 0;
    forever begin
      @(negedge clk);
      if (ready_s[g]) break;
      waits++;
      if (waits > 40) begin
        check($sformatf("req_timeout_i%0d", g), 32'(ready_s[g]), 32'd1);
        break;
      end
    end
    key = mkey(g, addr);
    if (ready_s[g]) begin
      if (strb != 4'd0) begin
        w = model.exists(key) ? model[key] : 32'd0;
        for (int i = 0; i < 4; i++) if (strb[i]) w[i*8 +: 8] = data[i*8 +: 8];
        model[key] = w;
      end else begin
        sb.push_back('{g: g, data: (model.exists(key) ? model[key] : 32'd0),
                       cyc: cyc + rd_lat(g)});
      end
    end
    @(posedge clk);
    #1;
    avalid_s[g] = 1'b0;
    wstrb_s[g]  = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response monitor: every rvalid pulse must match the oldest pending read of
  // that instance, at the expected cycle; overdue reads are reported missing.
  always @(negedge clk) begin : mon
    int idx;
    for (int g = 0; g < NI; g++) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].g == g) begin
          idx = i;
          break;
        end
      end
      if (rvalid_s[g]) begin
        if (idx < 0) begin
          check($sformatf("spurious_rvalid_i%0d", g), 32'(rvalid_s[g]), 32'd0);
        end else begin
          check($sformatf("rdata_i%0d", g), rdata_s[g], sb[idx].data);
          check($sformatf("rvalid_cycle_i%0d", g), 32'(cyc), 32'(sb[idx].cyc));
          sb.delete(idx);
        end
      end else if (idx >= 0 && sb[idx].cyc <= cyc) begin
        check($sformatf("missing_rvalid_i%0d", g), 32'(rvalid_s[g]), 32'd1);
        sb.delete(idx);
      end
    end
  end

  initial begin
    int          w;
    logic [31:0] a, d;
    logic [3:0]  s;
    n_checks = 0;
    n_fail   = 0;
    for (int g = 0; g < NI; g++) begin
      resetn_s[g]  = 1'b0;
      avalid_s[g]  = 1'b0;
      address_s[g] = 32'd0;
      wdata_s[g]   = 32'd0;
      wstrb_s[g]   = 4'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_ready_i%0d", g), 32'(ready_s[g]), 32'(wait_of(g) == 0));
      check($sformatf("rst_rvalid_i%0d", g), 32'(rvalid_s[g]), 32'd0);
      check($sformatf("rst_rdata_i%0d", g), rdata_s[g], 32'd0);
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) resetn_s[g] = 1'b1;

    // WAIT=0, RD_LAT=1: basic write/read, strobes, aliasing
    req(0, 32'h10, 32'hDEADBEEF, 4'hF, w); check("w0_wr_waits", 32'(w), 0);
    req(0, 32'h10, 32'h0, 4'h0, w);        check("w0_rd_waits", 32'(w), 0);
    req(0, 32'h20, 32'h11223344, 4'hF, w);
    req(0, 32'h20, 32'hAABBCCDD, 4'h5, w); check("w0_strb_waits", 32'(w), 0);
    req(0, 32'h20, 32'h0, 4'h0, w);
    req(0, 32'h1000, 32'h5A5A5A5A, 4'hF, w);
    req(0, 32'h0000, 32'h0, 4'h0, w);
    idle(2);
    for (int i = 0; i < 8; i++) req(0, 32'h100 + 32'(i * 4), $urandom, 4'hF, w);
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3) * 32'h1000);
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      req(0, a, d, s, w);
      check("w0_rand_waits", 32'(w), 0);
    end
    idle(2);

    // WAIT=3: three low-ready cycles before each acceptance; abort leaves memory alone
    req(1, 32'h30, 32'hCAFEF00D, 4'hF, w); check("w3_wr_waits", 32'(w), 3);
    req(1, 32'h10, 32'h0, 4'h0, w);        check("w3_rd_waits", 32'(w), 3);
    req(1, 32'h30, 32'h0, 4'h0, w);        check("w3_rd2_waits", 32'(w), 3);
    idle(2);
    avalid_s[1] = 1'b1; address_s[1] = 32'h30; wdata_s[1] = 32'h0; wstrb_s[1] = 4'hF;
    @(negedge clk); check("w3_abort_ready0", 32'(ready_s[1]), 0);
    @(posedge clk); #1;
    avalid_s[1] = 1'b0; wstrb_s[1] = 4'h0;
    @(negedge clk); check("w3_abort_ready1", 32'(ready_s[1]), 0);
    idle(2);
    req(1, 32'h30, 32'h0, 4'h0, w);        check("w3_post_abort_waits", 32'(w), 3);
    idle(2);

    // RD_LAT=3: back-to-back reads, ready low two cycles after each read accept
    req(2, 32'h10, 32'h01010101, 4'hF, w); check("l3_wr_waits", 32'(w), 0);
    req(2, 32'h14, 32'h02020202, 4'hF, w); check("l3_wr2_waits", 32'(w), 0);
    req(2, 32'h10, 32'h0, 4'h0, w);        check("l3_rd1_waits", 32'(w), 0);
    req(2, 32'h14, 32'h0, 4'h0, w);        check("l3_rd2_waits", 32'(w), 2);
    req(2, 32'h10, 32'h0, 4'h0, w);        check("l3_rd3_waits", 32'(w), 2);
    idle(5);

    // RD_LAT=2: reset while a read is in flight
    req(3, 32'h40, 32'h12345678, 4'hF, w);
    req(3, 32'h40, 32'h0, 4'h0, w);
    idle(3);
    avalid_s[3] = 1'b1; address_s[3] = 32'h40; wstrb_s[3] = 4'h0;
    @(negedge clk); check("l2_abort_rd_ready", 32'(ready_s[3]), 1);
    @(posedge clk); #1;
    avalid_s[3] = 1'b0;
    resetn_s[3] = 1'b0;
    #1;
    check("l2_rst_rvalid", 32'(rvalid_s[3]), 0);
    check("l2_rst_rdata", rdata_s[3], 32'd0);
    check("l2_rst_ready", 32'(ready_s[3]), 1);
    repeat (3) @(posedge clk);
    #1;
    resetn_s[3] = 1'b1;
    req(3, 32'h40, 32'h0, 4'h0, w);        check("l2_post_rst_waits", 32'(w), 0);
    idle(6);

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
